// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM encodings, byte width and index sizing.
package add_seq_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index must stay at least one bit wide even when NBYTES == 1.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Operand request / result handshake bundle between the datapath control
// unit (master) and the add/subtract sequencer (slave).
interface add_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic         in_ci;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport slave (
        input  in_valid, in_sub, in_ci, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_sub, in_ci, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/add_seq_ctrl_add8_core.sv
// Shared combinational 8-bit adder core: {Cout, S} = X + Y + Ci.
module add8_core (
    output logic [7:0] S,
    output logic       Cout,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic       Ci
);

    assign {Cout, S} = {1'b0, X} + {1'b0, Y} + {8'd0, Ci};

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: walks one 8-bit adder across
// NBYTES byte lanes LSB first, chaining the carry through a register.
//
// state | meaning
// IDLE  | waiting for an operand request, in_ready high
// RUN   | one byte lane per cycle through the shared adder
// DONE  | result valid, held until out_ready
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus
);

    localparam int                IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             c_q, c_d;
    word_t            xr_q, xr_d;
    word_t            yr_q, yr_d;
    word_t            s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BYTE_W-1:0] core_s;
    logic              core_co;

    add8_core u_core (
        .S    (core_s),
        .Cout (core_co),
        .X    (xr_q[idx_q]),
        .Y    (yr_q[idx_q]),
        .Ci   (c_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            xr_q    <= '0;
            yr_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is X + ~Y + 1, so in_ci is replaced by the forced 1.
                    xr_d    = bus.in_x;
                    yr_d    = bus.in_sub ? ~bus.in_y : bus.in_y;
                    c_d     = bus.in_sub ? 1'b1 : bus.in_ci;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q] = core_s;
                c_d        = core_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = core_co;
                    ovf_d   = (xr_q[NBYTES-1][BYTE_W-1] == yr_q[NBYTES-1][BYTE_W-1]) &&
                              (core_s[BYTE_W-1] != xr_q[NBYTES-1][BYTE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_s     = s_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (NBYTES=4) and the add8_core adder.
module tb_add_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic         sub;
        logic         ci;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    add_seq_ctrl_if #(.NBYTES(NB)) bus ();

    add_seq_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] cx, cy, cs;
    logic       cci, cco;

    add8_core u_core (
        .S    (cs),
        .Cout (cco),
        .X    (cx),
        .Y    (cy),
        .Ci   (cci)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic sub, input logic ci,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t       v;
        logic [W:0] r;
        v.sub = sub; v.ci = ci; v.x = x; v.y = y;
        if (sub) begin
            r     = {1'b0, x} - {1'b0, y};
            v.s   = r[W-1:0];
            v.cout = (x >= y);
            v.ovf = (x[W-1] != y[W-1]) && (v.s[W-1] != x[W-1]);
        end else begin
            r     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            v.s   = r[W-1:0];
            v.cout = r[W];
            v.ovf = (x[W-1] == y[W-1]) && (v.s[W-1] != x[W-1]);
        end
        return v;
    endfunction

    task automatic pop_and_compare(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_s"},    bus.out_s,    e.s);
            chk({tag, "_cout"}, bus.out_cout, e.cout);
            chk({tag, "_ovf"},  bus.out_ovf,  e.ovf);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_op(input vec_t v, input string tag);
        bus.in_sub    = v.sub;
        bus.in_ci     = v.ci;
        bus.in_x      = v.x;
        bus.in_y      = v.y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(v);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        for (int k = 1; k <= NB; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
            chk({tag, "_latency"}, bus.out_valid, (k == NB));
        end
        pop_and_compare(tag);
        @(posedge clk); #1;
        chk({tag, "_ov_drop"}, bus.out_valid, 1'b0);
        chk({tag, "_idle"},    bus.in_ready,  1'b1);
    endtask

    initial begin : main
        vec_t v;
        vec_t e;
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_ci     = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;

        // Reset with no clock edge yet
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_out_s",     bus.out_s,     32'h0);
        chk("rst_cout",      bus.out_cout,  1'b0);
        chk("rst_ovf",       bus.out_ovf,   1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs.push_back('{1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'h00000010, 32'h00000010, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h12345678, 32'h11111111, 32'h2345678A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h00000001, 1'b1, 1'b1});
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(model(1'($urandom_range(1)), 1'($urandom_range(1)),
                                 32'($urandom), 32'($urandom)));
        end

        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure in DONE while in_valid toggles
        v = '{1'b0, 1'b1, 32'h00001234, 32'h00000F0F, 32'h00002144, 1'b0, 1'b0};
        bus.in_sub = v.sub; bus.in_ci = v.ci; bus.in_x = v.x; bus.in_y = v.y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(v);
        for (int k = 1; k <= NB; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid", bus.out_valid, 1'b1);
        e = sb.pop_front();
        for (int n = 0; n < 5; n++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_x     = 32'hDEAD0000 | 32'(n);
            bus.in_sub   = 1'b1;
            @(posedge clk); #1;
            chk("bp_hold_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready",   bus.in_ready,  1'b0);
            chk("bp_hold_s",     bus.out_s,     e.s);
            chk("bp_hold_cout",  bus.out_cout,  e.cout);
            chk("bp_hold_ovf",   bus.out_ovf,   e.ovf);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.out_valid, 1'b0);
        chk("bp_release_ready", bus.in_ready,  1'b1);
        chk("bp_keep_s",        bus.out_s,     e.s);
        run_op('{1'b1, 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0}, "b2b");

        // Reset during the second RUN cycle
        bus.in_sub = 1'b0; bus.in_ci = 1'b0;
        bus.in_x = 32'hAAAAAAAA; bus.in_y = 32'h55555555;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  bus.in_ready,  1'b1);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy",      bus.busy,      1'b0);
        chk("mid_rst_out_s",     bus.out_s,     32'h0);
        chk("mid_rst_cout",      bus.out_cout,  1'b0);
        chk("mid_rst_ovf",       bus.out_ovf,   1'b0);
        for (int k = 0; k < NB + 2; k++) begin
            @(posedge clk); #1;
            if (k == 1) rst = 1'b0;
            chk("mid_rst_no_pulse", bus.out_valid, 1'b0);
        end
        run_op('{1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0}, "post_rst");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Exhaustive check of the shared byte adder
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [8:0] ref9;
                    cx  = 8'(a);
                    cy  = 8'(b);
                    cci = 1'(c);
                    #1;
                    ref9 = 9'(a + b + c);
                    chk($sformatf("core_%0d_%0d_%0d", a, b, c), {cco, cs}, ref9);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It drives one shared combinational 8-bit adder core across NBYTES byte lanes, LSB first, and chains the carry through a register between cycles. Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake that holds under backpressure. It sits between the datapath control unit and the 8-bit adder, so wide arithmetic reuses one narrow adder.

Parameters:
NBYTES, 4, number of byte lanes per operand (legal range 1..16); operand width W = 8*NBYTES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand request valid.
in_ready  output  1  controller can accept a request; high only in IDLE.
in_sub  input  1  1 = X - Y, 0 = X + Y + in_ci.
in_ci  input  1  carry-in for add; ignored when in_sub=1.
in_x  input  W  operand X.
in_y  input  W  operand Y.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
out_s  output  W  result register.
out_cout  output  1  final carry-out (for subtract, 1 = no borrow).
out_ovf  output  1  two's-complement signed overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface is fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_s=0, out_cout=0, out_ovf=0. Byte index and carry register are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid&&in_ready, latch in_x into xr.
  - Latch yr = in_sub ? ~in_y : in_y.
  - Load carry register c = in_sub ? 1 : in_ci.
  - Set idx=0, clear out_s to 0, go to RUN.
  - in_valid without in_ready is never accepted.
- RUN, each cycle:
  - Adder core gets X=xr[8*idx+:8], Y=yr[8*idx+:8], Ci=c.
  - Write the sum into out_s[8*idx+:8]; c <= core Cout.
  - If idx==NBYTES-1, go to DONE; otherwise idx <= idx+1.
  - in_ready=0; in_valid is ignored.
- Entering DONE:
  - out_cout = Cout of the last byte.
  - out_ovf = (xr[W-1]==yr[W-1]) && (sum MSB != xr[W-1]).
- DONE:
  - out_valid=1. out_s, out_cout and out_ovf are held stable while out_ready=0.
  - On out_ready=1, go to IDLE the next cycle. out_valid drops; out_s, out_cout and out_ovf keep their last values.
- Latency: out_valid rises exactly NBYTES cycles after the accepting edge.
- Minimum period per operation: NBYTES+2 cycles. There is no overlap: a new request is accepted only in IDLE, i.e. the cycle after the output handshake.
- NBYTES=1: RUN lasts one cycle.
- idx width is max(1, clog2(NBYTES)). idx never exceeds NBYTES-1.
- rst asserted mid-RUN or in DONE: immediate return to reset values. The in-flight result is discarded and out_valid is never pulsed.
- out_s contents during RUN are partial and are not checked. Only values with out_valid=1 are architecturally defined.

Decomposition:
- Shared package/include add_seq_defs: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; BYTE_W=8.
- Sub-module add8_core: a combinational 8-bit adder with ports S[7:0], Cout, X[7:0], Y[7:0], Ci. It is instantiated once, and the controller owns all registers.
- The bench checks add8_core separately, exhaustively against X+Y+Ci.

Test Plan:
1. Assert rst with no clock edge -> in_ready=1, out_valid=0, busy=0, out_s=0 immediately.
2. NBYTES=4: add 0x000000FF + 0x00000001, ci=0 -> out_valid on the 4th edge after accept; out_s=0x00000100, cout=0, ovf=0.
3. Add 0xFFFFFFFF + 0x00000001, ci=0 -> out_s=0x00000000, cout=1, ovf=0. Then 0x7FFFFFFF + 0x00000001 -> out_s=0x80000000, cout=0, ovf=1.
4. Subtract 0x00000005 - 0x00000007 -> out_s=0xFFFFFFFE, cout=0, ovf=0. Then 0x80000000 - 0x00000001 -> out_s=0x7FFFFFFF, cout=1, ovf=1.
5. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE next cycle; a back-to-back request is accepted the cycle after.
6. Assert rst during the 2nd RUN cycle -> all outputs at reset values at once; no out_valid pulse. A following add 0x12345678 + 0x11111111 returns 0x23456789.
